// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture family: default widths,
// capture FSM states and an all-ones helper for parameterised widths.
package pwm_pkg;

  localparam int unsigned BIT_WIDTH_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } cap_state_e;

  // Counter width leaves headroom over the generator resolution.
  function automatic int unsigned cnt_width_of(input int unsigned bw);
    return bw + 2;
  endfunction

  // Saturation value for a counter of width w (w <= 64).
  function automatic logic [63:0] all_ones(input int unsigned w);
    logic [63:0] r;
    if (w >= 64) r = '1;
    else r = (64'd1 << w) - 64'd1;
    return r;
  endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Module pwm_sync_edge: multi-flop synchronizer for an asynchronous input plus
// a delay flop for rising-edge detection. Reusable for any async level input.
module pwm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pwm_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];
  // Combinational so the capture counters can restart in the edge cycle.
  assign rise  = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an incoming PWM waveform and
// flags a stuck line. Optional 4-period averaging under PWM_CAPTURE_AVG_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned bit_width   = BIT_WIDTH_DEFAULT,
  parameter int unsigned CNT_WIDTH   = cnt_width_of(bit_width),
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] duty_cnt,
  output logic [CNT_WIDTH-1:0] period_cnt,
  output logic                 valid,
  output logic                 stuck,
  output logic                 level
);

  localparam logic [CNT_WIDTH-1:0] ONES = CNT_WIDTH'(all_ones(CNT_WIDTH));

  logic                 pwm_s;
  logic                 rise;
  logic [CNT_WIDTH-1:0] per_cnt;
  logic [CNT_WIDTH-1:0] hi_cnt;

  cap_state_e           state_q;
  cap_state_e           state_d;
  logic [CNT_WIDTH-1:0] duty_d;
  logic [CNT_WIDTH-1:0] period_d;
  logic                 valid_d;
  logic                 stuck_d;
  logic                 level_d;

`ifdef PWM_CAPTURE_AVG_EN
  localparam int unsigned ACC_WIDTH = CNT_WIDTH + 2;

  logic [ACC_WIDTH-1:0] acc_per_q;
  logic [ACC_WIDTH-1:0] acc_per_d;
  logic [ACC_WIDTH-1:0] acc_hi_q;
  logic [ACC_WIDTH-1:0] acc_hi_d;
  logic [ACC_WIDTH-1:0] sum_per;
  logic [ACC_WIDTH-1:0] sum_hi;
  logic [1:0]           nsamp_q;
  logic [1:0]           nsamp_d;
`endif

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .pwm_s(pwm_s),
    .rise (rise)
  );

  // Period and high-time counters restart on each rising edge and saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_WIDTH'(1);
      hi_cnt  <= CNT_WIDTH'(1);
    end else begin
      if (per_cnt != ONES) per_cnt <= per_cnt + CNT_WIDTH'(1);
      if (pwm_s && (hi_cnt != ONES)) hi_cnt <= hi_cnt + CNT_WIDTH'(1);
    end
  end

  // Capture FSM: next state and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_cnt;
    period_d = period_cnt;
    valid_d  = 1'b0;
    level_d  = level;
`ifdef PWM_CAPTURE_AVG_EN
    acc_per_d = acc_per_q;
    acc_hi_d  = acc_hi_q;
    nsamp_d   = nsamp_q;
    sum_per   = acc_per_q + ACC_WIDTH'(per_cnt);
    sum_hi    = acc_hi_q + ACC_WIDTH'(hi_cnt);
`endif

    unique case (state_q)
      IDLE: begin
        if (rise) state_d = MEAS;
      end

      MEAS: begin
        if (rise) begin
`ifdef PWM_CAPTURE_AVG_EN
          if (nsamp_q == 2'd3) begin
            period_d  = CNT_WIDTH'(sum_per >> 2);
            duty_d    = CNT_WIDTH'(sum_hi >> 2);
            valid_d   = 1'b1;
            acc_per_d = '0;
            acc_hi_d  = '0;
            nsamp_d   = 2'd0;
          end else begin
            acc_per_d = sum_per;
            acc_hi_d  = sum_hi;
            nsamp_d   = nsamp_q + 2'd1;
          end
`else
          period_d = per_cnt;
          duty_d   = hi_cnt;
          valid_d  = 1'b1;
`endif
        end else if (per_cnt == ONES) begin
          // No edge for a full counter range: report the static level.
          state_d  = STUCK;
          period_d = ONES;
          duty_d   = pwm_s ? ONES : '0;
          level_d  = pwm_s;
          valid_d  = 1'b1;
`ifdef PWM_CAPTURE_AVG_EN
          acc_per_d = '0;
          acc_hi_d  = '0;
          nsamp_d   = 2'd0;
`endif
        end
      end

      STUCK: begin
        if (rise) state_d = MEAS;
      end

      default: state_d = IDLE;
    endcase

    stuck_d = (state_d == STUCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      duty_cnt   <= '0;
      period_cnt <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
      level      <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_cnt   <= duty_d;
      period_cnt <= period_d;
      valid      <= valid_d;
      stuck      <= stuck_d;
      level      <= level_d;
    end
  end

`ifdef PWM_CAPTURE_AVG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_per_q <= '0;
      acc_hi_q  <= '0;
      nsamp_q   <= 2'd0;
    end else begin
      acc_per_q <= acc_per_d;
      acc_hi_q  <= acc_hi_d;
      nsamp_q   <= nsamp_d;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: timestamp-based reference model compared
// every cycle, directed scenarios with literal expectations, then random PWM.
module tb_pwm_capture;

  localparam int unsigned BW   = 10;
  localparam int unsigned CW   = BW + 2;
  localparam int unsigned SYNC = 2;
  localparam int unsigned ONES = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          pwm_in;
  logic [CW-1:0] duty_cnt;
  logic [CW-1:0] period_cnt;
  logic          valid;
  logic          stuck;
  logic          level;

  pwm_capture #(
    .bit_width  (BW),
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .duty_cnt  (duty_cnt),
    .period_cnt(period_cnt),
    .valid     (valid),
    .stuck     (stuck),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Works from rise timestamps and a running total of high samples, not counters.
  bit          hist [SYNC+1];
  bit          started = 1'b0;
  bit          have_ref, in_stuck;
  int unsigned t, rise_t, h_total, h_at_rise;
  int unsigned exp_period, exp_duty;
  bit          exp_valid, exp_stuck, exp_level;
  int unsigned q_per[$];
  int unsigned q_hi[$];

  function automatic int unsigned sat(input int unsigned v);
    return (v > ONES) ? ONES : v;
  endfunction

  task automatic model_report(input int unsigned p, input int unsigned d);
`ifdef PWM_CAPTURE_AVG_EN
    int unsigned sp, sd;
    q_per.push_back(p);
    q_hi.push_back(d);
    if (q_per.size() == 4) begin
      sp = 0;
      sd = 0;
      foreach (q_per[i]) begin
        sp += q_per[i];
        sd += q_hi[i];
      end
      exp_period = sp / 4;
      exp_duty   = sd / 4;
      exp_valid  = 1'b1;
      q_per.delete();
      q_hi.delete();
    end
`else
    exp_period = p;
    exp_duty   = d;
    exp_valid  = 1'b1;
`endif
  endtask

  always @(posedge clk) begin
    bit s, prev, r;
    int unsigned age;
    if (rst) begin
      for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
      have_ref   = 1'b0;
      in_stuck   = 1'b0;
      exp_period = 0;
      exp_duty   = 0;
      exp_valid  = 1'b0;
      exp_stuck  = 1'b0;
      exp_level  = 1'b0;
      h_total    = 0;
      h_at_rise  = 0;
      rise_t     = t;
      q_per.delete();
      q_hi.delete();
    end else begin
      s   = hist[SYNC-1];
      prev = hist[SYNC];
      r   = s & ~prev;
      age = t - rise_t;
      exp_valid = 1'b0;
      if (r) begin
        if (have_ref && !in_stuck) model_report(sat(age), sat(h_total - h_at_rise));
        have_ref  = 1'b1;
        in_stuck  = 1'b0;
        rise_t    = t;
        h_at_rise = h_total;
      end else if (have_ref && !in_stuck && age == ONES) begin
        in_stuck   = 1'b1;
        exp_period = ONES;
        exp_duty   = s ? ONES : 0;
        exp_level  = s;
        exp_valid  = 1'b1;
        q_per.delete();
        q_hi.delete();
      end
      exp_stuck = in_stuck;
      h_total  += 32'(s);
      for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pwm_in;
    end
    t++;
    started = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      check("valid", 32'(valid), 32'(exp_valid));
      check("period_cnt", 32'(period_cnt), exp_period);
      check("duty_cnt", 32'(duty_cnt), exp_duty);
      check("stuck", 32'(stuck), 32'(exp_stuck));
      check("level", 32'(level), 32'(exp_level));
      check("duty_le_period", 32'(duty_cnt <= period_cnt), 32'd1);
    end
  end

  // Records valid strobes for the directed literal checks.
  int unsigned vcount = 0;
  int unsigned last_p = 0;
  int unsigned last_d = 0;
  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      last_p = 32'(period_cnt);
      last_d = 32'(duty_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input bit v, input int unsigned n);
    pwm_in = v;
    repeat (n) tick();
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, 32'(period_cnt), 0);
    check({tag, "_duty"}, 32'(duty_cnt), 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_stuck"}, 32'(stuck), 0);
    check({tag, "_level"}, 32'(level), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int unsigned base;

  initial begin
    t      = 0;
    rst    = 1'b1;
    pwm_in = 1'b0;
    // Reset with a toggling input clears everything.
    repeat (3) begin
      pwm_in = ~pwm_in;
      tick();
    end
    settle();
    check_zero("reset");
    rst = 1'b0;
    hold(1'b0, 3);

    base = vcount;
    pulse(3, 7);
    settle();
    check("first_rise_no_valid", vcount - base, 0);

    base = vcount;
    repeat (5) pulse(3, 7);
    settle();
`ifdef PWM_CAPTURE_AVG_EN
    check("steady_valids", vcount - base, 1);
`else
    check("steady_valids", vcount - base, 5);
`endif
    check("steady_period", last_p, 10);
    check("steady_duty", last_d, 3);
    check("steady_stuck", 32'(stuck), 0);

    // Stuck low.
    base = vcount;
    hold(1'b0, 4200);
    settle();
    check("stuck_lo_valids", vcount - base, 1);
    check("stuck_lo_period", last_p, 4095);
    check("stuck_lo_duty", last_d, 0);
    check("stuck_lo_flag", 32'(stuck), 1);
    check("stuck_lo_level", 32'(level), 0);

    // Stuck high: the first rise leaves STUCK silently, then it re-sticks high.
    base = vcount;
    hold(1'b1, 4200);
    settle();
    check("stuck_hi_valids", vcount - base, 1);
    check("stuck_hi_period", last_p, 4095);
    check("stuck_hi_duty", last_d, 4095);
    check("stuck_hi_flag", 32'(stuck), 1);
    check("stuck_hi_level", 32'(level), 1);

    // Recovery with 5/5 PWM.
    base = vcount;
    hold(1'b0, 5);
    hold(1'b1, 5);
    settle();
    check("recover_stuck_clear", 32'(stuck), 0);
    check("recover_no_valid", vcount - base, 0);
    hold(1'b0, 5);
    repeat (3) pulse(5, 5);
    settle();
`ifndef PWM_CAPTURE_AVG_EN
    check("recover_valids", vcount - base, 3);
    check("recover_period", last_p, 10);
    check("recover_duty", last_d, 5);
`else
    check("recover_valids", vcount - base, 0);
`endif

    // Reset in the middle of a measurement.
    repeat (3) pulse(3, 7);
    hold(1'b1, 3);
    hold(1'b0, 3);
    rst = 1'b1;
    tick();
    tick();
    settle();
    check_zero("midreset");
    rst = 1'b0;
    hold(1'b0, 2);
    base = vcount;
    pulse(3, 7);
    settle();
    check("midreset_first_rise", vcount - base, 0);
    pulse(3, 7);
    settle();
`ifndef PWM_CAPTURE_AVG_EN
    check("midreset_valids", vcount - base, 1);
    check("midreset_period", last_p, 10);
    check("midreset_duty", last_d, 3);
`else
    check("midreset_valids", vcount - base, 0);
`endif

    // Alternating 10/12 periods from a clean reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold(1'b0, 3);
    pulse(3, 7);
    base = vcount;
    pulse(5, 7);
    pulse(3, 7);
    pulse(5, 7);
    pulse(3, 3);
    settle();
`ifdef PWM_CAPTURE_AVG_EN
    check("avg_valids", vcount - base, 1);
    check("avg_period", last_p, 11);
    check("avg_duty", last_d, 4);
`else
    check("alt_valids", vcount - base, 4);
    check("alt_period", last_p, 12);
    check("alt_duty", last_d, 5);
`endif

    // Minimum resolvable pulse: 1 high + 1 low.
    repeat (6) pulse(1, 1);
    settle();
`ifndef PWM_CAPTURE_AVG_EN
    check("min_period", last_p, 2);
    check("min_duty", last_d, 1);
`endif

    // Random PWM with occasional resets; the model checks every cycle.
    repeat (300) begin
      pulse($urandom_range(1, 20), $urandom_range(1, 20));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b0;
      end
    end
    hold(1'b0, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of pwm_module: measures an incoming PWM waveform.
- Reports high time and period in clock cycles.
- Flags a stuck-static input (0%/100% duty or dead line).
- Sits behind an input pin or a loopback from pwm_module; results feed status registers and the GPU control path.

Parameters:
- bit_width, 10, resolution of the matching pwm_module duty/max_value.
- CNT_WIDTH, bit_width+2, width of the internal counters and the measurement outputs.
- SYNC_STAGES, 2, number of flops in the pwm_in synchronizer (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- pwm_in  in  1  asynchronous PWM input.
- duty_cnt  out  CNT_WIDTH  high cycles in the last complete period.
- period_cnt  out  CNT_WIDTH  cycles between the last two rising edges.
- valid  out  1  one-cycle strobe when duty_cnt/period_cnt update.
- stuck  out  1  high while pwm_in has had no rising edge for 2^CNT_WIDTH-1 cycles.
- level  out  1  static level of pwm_in when stuck was raised.

Behaviour:
- Reset:
  - rst sampled high at a clk edge clears every output, counter, synchronizer flop and accumulator to 0.
  - FSM goes to IDLE.
  - Applies mid-measurement too: any partial measurement is discarded.
- Synchronizer and edge detect:
  - pwm_in passes through SYNC_STAGES flops to give pwm_s.
  - pwm_d is pwm_s delayed one cycle.
  - rise = pwm_s & ~pwm_d.
- Counters (per_cnt, hi_cnt), updated every cycle:
  - On a rise cycle both load 1.
  - Otherwise per_cnt += 1 and hi_cnt += pwm_s.
  - Both saturate at all-ones and never wrap.
- FSM states:
  - IDLE: no reference edge yet. On rise, go to MEAS; no valid.
  - MEAS, on rise:
    - Register period_cnt <= per_cnt and duty_cnt <= hi_cnt.
    - Pulse valid on the next cycle; stay in MEAS.
  - MEAS, per_cnt reaching all-ones without a rise:
    - Go to STUCK.
    - Register period_cnt <= all-ones, duty_cnt <= (pwm_s ? all-ones : 0), level <= pwm_s.
    - Pulse valid once.
  - STUCK: stuck = 1. On rise: stuck <= 0, go to MEAS, counters load 1, no valid (no reference edge yet).
- Timing:
  - With SYNC_STAGES=2, valid is high in the cycle after the 3rd clk edge counted from the edge that first samples the new pwm_in rise.
  - duty_cnt and period_cnt hold their value between valid strobes.
- Width and precision:
  - Measurements are exact for periods up to 2^CNT_WIDTH-2 cycles.
  - Invariant: duty_cnt <= period_cnt always.
  - A period of 1 cycle cannot be resolved; the minimum measurable pulse is 1 high cycle plus 1 low cycle.
- Glitches: pulses shorter than one clk may be missed; this is acceptable and not flagged.

Optional Feature:
- Macro: PWM_CAPTURE_AVG_EN.
- With the macro defined:
  - Each MEAS rise adds per_cnt/hi_cnt into (CNT_WIDTH+2)-bit accumulators and increments a 2-bit sample count.
  - On the 4th sample, outputs = accumulator >> 2 (truncated), valid pulses, and the accumulators clear.
  - Entering STUCK or IDLE clears the accumulators; the STUCK report is unaveraged.
- Without the macro: per-period reporting exactly as in Behaviour.

Decomposition:
- Shared package pwm_pkg:
  - default CNT_WIDTH derivation (bit_width+2);
  - capture FSM state enum (IDLE, MEAS, STUCK);
  - all-ones constant helper.
- Sub-module pwm_sync_edge: SYNC_STAGES synchronizer plus delay flop; outputs pwm_s and rise. Reusable for other async inputs.

Test Plan:
- Reset: hold rst=1 for 3 clks with pwm_in toggling -> all outputs 0; after release, the first rise produces no valid.
- Steady PWM, 3 clks high / 7 clks low, repeated -> from the 2nd rise onward, valid once every 10 clks with period_cnt=10, duty_cnt=3, stuck=0.
- Stuck low: steady PWM then pwm_in held 0 (CNT_WIDTH=12) -> 4095 cycles after the last rise, valid with period_cnt=4095, duty_cnt=0, stuck=1, level=0.
- Stuck high: pwm_in held 1 -> valid with period_cnt=4095, duty_cnt=4095, stuck=1, level=1. Then 5-high/5-low PWM resumes -> stuck clears at the 1st rise with no valid; the 2nd rise gives period_cnt=10, duty_cnt=5.
- Reset mid-measurement: pulse rst in the middle of a 3/7 stream -> outputs 0; no valid until 2 rises after reset, then 10/3.
- AVG_EN build: periods 10, 12, 10, 12 with high times 3, 5, 3, 5 -> a single valid after the 4th period with period_cnt=11, duty_cnt=4.
